// File: rtl/mem_pipelined_model_if.sv
// Request/response bus between the cache fill machine and the memory model.
// Handshake: enable is a request valid with an implicit, always-asserted
// ready -- the memory accepts a request at every rising edge where
// enable=1 (wr selects write vs. read). data_valid is a one-cycle response
// strobe with no ready; the consumer must take data_out in that cycle.
interface mem_pipelined_model_if;
  logic        enable;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        data_valid;

  modport master (
    output enable, wr, addr, data_in,
    input  data_out, data_valid
  );

  modport slave (
    input  enable, wr, addr, data_in,
    output data_out, data_valid
  );
endinterface

// File: rtl/mem_pipelined_model.sv
// Behavioural pipelined main-memory model feeding the cache fill machine.
// 16-bit words, byte addressing (addr[0] ignored), fixed read latency of
// LATENCY cycles, one request per cycle, responses in issue order.
// Optional build macro MEM_INFLIGHT_WRITE_UPDATE_EN: a write also refreshes
// the data of any in-flight read to the same word, so the read returns the
// newest value. Without it, reads return the value captured at issue.
module mem_pipelined_model #(
  parameter int LATENCY = 4,
  parameter int ADDR_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_pipelined_model_if.slave  bus
);

  localparam int DEPTH = 1 << (ADDR_W - 1);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-2:0] idx;
    logic [15:0]       data;
  } stage_t;

  logic [15:0]       mem [DEPTH];
  stage_t            stg [LATENCY];

  logic [ADDR_W-2:0] req_idx;
  logic              do_write;
  logic              do_read;
  logic              unused_addr_bit0;

  assign req_idx          = bus.addr[ADDR_W-1:1];
  assign do_write         = bus.enable & bus.wr;
  assign do_read          = bus.enable & ~bus.wr;
  assign unused_addr_bit0 = bus.addr[0];

  // Array write; a request arriving while reset is asserted is dropped.
  always_ff @(posedge clk) begin
    if (rst && do_write) begin
      mem[req_idx] <= bus.data_in;
    end
  end

  // Read pipeline: stage 0 captures the word at the request edge, then the
  // entry shifts one stage per cycle. Reset kills every in-flight entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        stg[i] <= '0;
      end
    end else begin
      stg[0].valid <= do_read;
      stg[0].idx   <= req_idx;
      stg[0].data  <= mem[req_idx];
      for (int i = 1; i < LATENCY; i++) begin
        stg[i].valid <= stg[i-1].valid;
        stg[i].idx   <= stg[i-1].idx;
`ifdef MEM_INFLIGHT_WRITE_UPDATE_EN
        // The write lands on the entry as it moves into its next stage.
        if (do_write && stg[i-1].valid && (stg[i-1].idx == req_idx)) begin
          stg[i].data <= bus.data_in;
        end else begin
          stg[i].data <= stg[i-1].data;
        end
`else
        stg[i].data  <= stg[i-1].data;
`endif
      end
    end
  end

  // Response is the last stage; data is forced to zero when not valid.
  assign bus.data_valid = stg[LATENCY-1].valid;
  assign bus.data_out   = stg[LATENCY-1].valid ? stg[LATENCY-1].data : 16'h0000;

endmodule

// File: doc/mem_pipelined_model.md
Name: mem_pipelined_model

Overview:
- Behavioural main-memory model that sits directly downstream of the cache fill state machine.
- Accepts read and write requests on the memory address bus and returns read data after a fixed pipelined latency, with a one-cycle valid strobe.
- This is the producer of memory_data / memory_data_valid for the fill machine.
- Word-organised: 16-bit words, byte addressing, addr[0] ignored.

Parameters:
- LATENCY, 4: cycles from read-request edge to data_valid; legal range 1..8.
- ADDR_W, 16: implemented byte-address bits. Array depth is 2^(ADDR_W-1) words. Bits above ADDR_W-1 are ignored.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
- enable  input  1  request valid this cycle.
- wr  input  1  1 = write request, 0 = read request; ignored when enable=0.
- addr  input  16  byte address; word index = addr[ADDR_W-1:1].
- data_in  input  16  write data; sampled when enable=1 and wr=1.
- data_out  output  16  read data; 0 whenever data_valid=0.
- data_valid  output  1  high for exactly one cycle per completed read.

Behaviour:
- Reset (rst=0 at an edge):
  - data_valid=0 and data_out=0 from the following cycle.
  - All in-flight pipeline stages are cleared; their valids are set to 0.
  - Array contents are not affected.
- Write (enable=1, wr=1):
  - mem[addr[ADDR_W-1:1]] <= data_in at that edge.
  - No response is generated and data_valid is not touched.
- Read (enable=1, wr=0):
  - Word mem[index] is captured into pipeline stage 1 at the request edge.
  - The capture reflects all writes committed at earlier edges.
  - Data advances one stage per cycle.
  - A read issued at edge t gives data_valid=1 and data_out=word during the cycle following edge t+LATENCY-1, i.e. visible LATENCY cycles after the request cycle.
- Fully pipelined:
  - One request is accepted every cycle, with no stall or backpressure.
  - Up to LATENCY reads may be in flight.
  - Responses return strictly in issue order, one per cycle, with no gaps for back-to-back reads.
- enable=0: nothing enters the pipeline. The bubble propagates as data_valid=0 in the corresponding output cycle.
- Pipeline state is LATENCY stages of {valid, addr_index, data}. The addr_index is kept for the optional feature.
- Boundaries:
  - LATENCY=1: data_valid appears the cycle after the request.
  - An odd addr behaves identically to addr & ~1.
  - Address wrap: index uses only addr[ADDR_W-1:1].
  - Reset with reads in flight: those reads never produce data_valid. A request presented in the same cycle as rst=0 is dropped.
- Single request port: read and write cannot occur in the same cycle.

Optional Feature:
- Macro: MEM_INFLIGHT_WRITE_UPDATE_EN.
- Defined:
  - A write at edge t updates the data field of every in-flight read stage whose addr_index matches the write index.
  - The read therefore returns the newest value written before its data_valid cycle.
- Undefined: reads return the value captured at issue time; later writes never alter in-flight data.
- Array write behaviour is identical in both builds.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with enable=1, wr=0 -> data_valid=0 and data_out=0x0000 throughout, and for LATENCY cycles after release.
2. Basic write then read (LATENCY=4):
   - Stimulus: write 0xBEEF @0x0010, then read 0x0010 at cycle c.
   - Required: data_valid=1 with data_out=0xBEEF exactly in cycle c+4, and data_valid=0 in c+3 and c+5.
3. Back-to-back reads:
   - Stimulus: preload words 0x1000..0x1007 at 0x0000..0x000E, then issue 8 consecutive reads.
   - Required: 8 consecutive data_valid cycles returning 0x1000..0x1007 in order.
   - Repeat with enable=0 inserted after the 3rd read -> exactly one data_valid=0 gap at the matching position.
4. Mid-operation reset:
   - Stimulus: issue 3 reads, then rst=0 for one cycle at the cycle after the 3rd.
   - Required: no data_valid for any of the 3 reads. A new read after release returns correctly after 4 cycles.
5. In-flight write:
   - Stimulus: mem[0x0020]=0x1111; read 0x0020 at c; write 0x2222 @0x0020 at c+1.
   - Required: returns 0x1111 without the macro, 0x2222 with MEM_INFLIGHT_WRITE_UPDATE_EN defined.
6. Alignment and LATENCY=1:
   - Stimulus: read 0x0011 after writing 0xA5A5 @0x0010.
   - Required: returns 0xA5A5. With LATENCY=1, data_valid appears in the next cycle.
